// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'hD503201F;
    localparam logic [63:0] PC_STEP   = 64'd4;
    localparam int          CNT_W     = 4;

    // Instruction addresses are word aligned; the low two bits are dropped.
    localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

    // Saturating increment for the bubble counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// Purpose: IF/ID pipeline register with load enable and flush-to-bubble.
// Latency: 1 cycle from pc_in/instr_in to pc/instr.
// Backpressure: load=0 holds contents; flush overrides load and inserts a NOP bubble.
//
// Ports: clk, rst (async, active high); load, flush controls;
//        pc_in/instr_in capture data; valid/pc/instr registered outputs.
module fetch_ifid_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [63:0] pc_in,
    input  logic [31:0] instr_in,
    output logic        valid,
    output logic [63:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= 64'd0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            // Bubble: pc is left alone, only valid/instr are forced.
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_in;
            instr <= instr_in;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Purpose: owns the fetch PC; advances, stalls or redirects it and fills IF/ID.
// Latency: instruction at fetch_pc lands in IF/ID on the next edge; redirect costs 1+FLUSH_CYCLES bubbles.
// Backpressure: stall holds PC and IF/ID in RUN; ignored during FLUSH; redirect always wins.
//
// Ports: clk, reset (async, active high); stall, redirect, redirect_pc from hazard/branch logic;
//        fetch_instr from instruction memory; fetch_pc to instruction memory;
//        ifid_valid/ifid_pc/ifid_instr to decode; flush_count saturating bubble counter.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [63:0] PC_RESET     = 64'h0,
    parameter int          FLUSH_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic [31:0] fetch_instr,
    output logic [63:0] fetch_pc,
    output logic        ifid_valid,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [15:0] flush_count
);

    // Value loaded into the bubble counter when a flush window opens.
    localparam int               FLUSH_LAST = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_INIT   = FLUSH_LAST[CNT_W-1:0];
    localparam fetch_state_t     OPEN_STATE = (FLUSH_CYCLES > 0) ? FLUSH : RUN;

    fetch_state_t     state;
    logic [CNT_W-1:0] cnt;

    logic ifid_flush;
    logic ifid_load;

    // Redirect and every FLUSH slot produce a bubble; otherwise load unless stalled.
    always_comb begin
        ifid_flush = redirect || (state == FLUSH);
        ifid_load  = !stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= OPEN_STATE;
            cnt         <= CNT_INIT;
            fetch_pc    <= PC_RESET;
            flush_count <= 16'd0;
        end else if (redirect) begin
            state       <= OPEN_STATE;
            cnt         <= CNT_INIT;
            fetch_pc    <= redirect_pc & PC_ALIGN_MASK;
            flush_count <= sat_inc16(flush_count);
        end else if (state == FLUSH) begin
            flush_count <= sat_inc16(flush_count);
            if (cnt == '0) begin
                state <= RUN;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (!stall) begin
            // Wraps modulo 2^64 by construction.
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    fetch_ifid_reg u_ifid (
        .clk      (clk),
        .rst      (reset),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .pc_in    (fetch_pc),
        .instr_in (fetch_instr),
        .valid    (ifid_valid),
        .pc       (ifid_pc),
        .instr    (ifid_instr)
    );

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the instruction-fetch stage of the 5-stage pipeline and owns the fetch PC register.
- Each cycle it decides whether to advance the PC by 4, hold for a hazard stall, or redirect to a branch target resolved downstream.
- Drives the instruction-memory address and captures the returned instruction into the IF/ID pipeline register, inserting bubbles after redirects.
- Sits between the hazard/branch-resolution logic and the decode stage.

Parameters:
PC_RESET, 64'h0, fetch PC value loaded on reset.
FLUSH_CYCLES, 0, extra bubble cycles held after a redirect or reset; legal range 0..15.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hazard-unit stall: hold PC and IF/ID contents.
redirect  input  1  taken branch resolved downstream; load redirect_pc.
redirect_pc  input  64  branch target address.
fetch_instr  input  32  instruction memory read data for fetch_pc, valid in the same cycle.
fetch_pc  output  64  address presented to instruction memory.
ifid_valid  output  1  IF/ID register holds a real instruction.
ifid_pc  output  64  PC of the instruction in IF/ID.
ifid_instr  output  32  instruction in IF/ID; NOP when invalid.
flush_count  output  16  saturating count of bubble slots caused by redirect/flush (not stall).

Behaviour:
- Reset (async, any time, including mid-flush):
  - fetch_pc=PC_RESET, ifid_valid=0, ifid_pc=0, ifid_instr=NOP (32'hD503201F), flush_count=0.
  - state=FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>0; otherwise state=RUN.
- States: RUN, FLUSH. Per-edge priority is redirect > FLUSH handling > stall > normal advance.
- Redirect (any state, regardless of stall):
  - fetch_pc<={redirect_pc[63:2],2'b00}; low two bits are discarded.
  - ifid_valid<=0, ifid_instr<=NOP, flush_count increments.
  - FLUSH_CYCLES=0: stay/enter RUN. Otherwise enter FLUSH with cnt<=FLUSH_CYCLES-1.
  - A redirect arriving during FLUSH restarts the flush with the new target.
- FLUSH, no redirect:
  - fetch_pc holds, ifid_valid<=0, ifid_instr<=NOP, flush_count increments.
  - cnt==0 -> RUN; otherwise cnt decrements.
  - stall is ignored in FLUSH, since its slots are bubbles anyway.
- RUN, stall=1, no redirect: fetch_pc, ifid_* and flush_count all hold.
- RUN, normal: ifid_pc<=fetch_pc, ifid_instr<=fetch_instr, ifid_valid<=1, fetch_pc<=fetch_pc+4.
- Latency with FLUSH_CYCLES=0:
  - The instruction at redirect target T is in IF/ID one edge after the redirect is loaded, i.e. one bubble.
  - Each additional FLUSH_CYCLES adds one bubble.
- Arithmetic: fetch_pc+4 wraps modulo 2^64 (FFFF_FFFF_FFFF_FFFC -> 0); no error flag.
- flush_count saturates at 16'hFFFF and never wraps.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package fetch_pkg:
  - state enum {RUN, FLUSH}
  - NOP_INSTR=32'hD503201F
  - PC_STEP=64'd4
  - flush counter width (4 bits)
- Sub-module fetch_ifid_reg: IF/ID register with load-enable (hold on stall) and a flush input that forces valid=0 and instr=NOP.
- The state machine, PC register, +4 adder and saturating counter stay in fetch_controller.

Test Plan:
- Straight-line: reset with PC_RESET=0, release, fetch_instr driven from a memory model, no stall/redirect, 4 cycles -> ifid_pc sequence 0,4,8,12 with ifid_valid=1; flush_count=0.
- Stall: stall=1 for 3 cycles while ifid_pc=8 -> fetch_pc stays 12, ifid_pc/ifid_instr unchanged, flush_count unchanged; stall released -> next ifid_pc=12.
- Redirect during stall: stall=1 and redirect=1 with redirect_pc=64'h103 -> fetch_pc=64'h100, ifid_valid=0, ifid_instr=NOP, flush_count=1; next edge ifid_pc=64'h100, valid=1.
- Flush length: FLUSH_CYCLES=2, redirect to 64'h200 -> exactly 3 ifid_valid=0 slots, flush_count=3, then ifid_pc=64'h200; a second redirect to 64'h300 during FLUSH restarts the count and lands at 64'h300.
- Wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC, run 2 cycles -> ifid_pc FFFF_FFFF_FFFF_FFFC then 0.
- Async reset mid-flush and saturation:
  - Assert reset between edges during FLUSH -> outputs immediately return to reset values.
  - Force 65540 redirects -> flush_count holds at 16'hFFFF.
